hack_alu_stage: RTL and testbench
=================================

Name: hack_alu_stage

Overview:
- Registered Hack ALU stage that sits directly downstream of the 16-bit bitwise AND datapath.
- Consumes operand pairs x/y plus the six Hack control bits (zx nx zy ny f no).
- Computes the Hack ALU result and flags, then presents them through a valid/ready output interface with a 2-entry skid buffer. Upstream is never stalled combinationally by downstream backpressure.
- Feeds the D/A/M writeback path in the CPU.

Parameters:
- WIDTH, 16: datapath width of x, y and out. Only 16 is used in the Hack CPU; the RTL must remain generic.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operand beat present
- in_ready  output  1  stage can accept a beat this cycle
- x  input  WIDTH  operand x (D register side)
- y  input  WIDTH  operand y (A/M side)
- ctrl  input  6  {zx,nx,zy,ny,f,no}, ctrl[5]=zx
- out_valid  output  1  result beat present
- out_ready  input  1  downstream accepts result
- out  output  WIDTH  ALU result
- zr  output  1  out == 0
- ng  output  1  out[WIDTH-1]

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, named reset. It is sampled only on the rising edge of clk.
- Reset values: out_valid=0, out=0, zr=0, ng=0, in_ready=1 from the first cycle after reset, both buffer entries invalid.
- Reset mid-operation discards all buffered beats; no beat is emitted afterward.
- ALU function, pure combinational on the input side:
  - x1 = zx?0:x; x2 = nx?~x1:x1
  - y1 = zy?0:y; y2 = ny?~y1:y1
  - r = f?(x2+y2 mod 2^WIDTH):(x2&y2)
  - res = no?~r:r
- Flags: zr = (res==0); ng = res[WIDTH-1]. Both are computed before registering, so they travel with their beat.
- Handshake: a transfer occurs on a cycle where valid && ready.
  - in_ready is a registered output: in_ready = !skid_valid.
  - Once out_valid=1, it is not deasserted and out/zr/ng are not changed until out_ready=1.
- Latency: a beat accepted at edge N is visible on out at edge N (out_valid=1 in cycle N+1) when the main register is free. Minimum latency is 1 cycle.
- Throughput: 1 beat/cycle while out_ready=1.
- State machine, encoded by {main_valid, skid_valid}:
  - EMPTY (00): accept -> ONE.
  - ONE (10):
    - accept && out_ready -> ONE; main is reloaded with the new beat.
    - accept && !out_ready -> TWO; the new beat goes into skid.
    - !accept && out_ready -> EMPTY.
    - otherwise stay.
  - TWO (11): in_ready=0, no accept. out_ready -> ONE, skid moves to main. Otherwise stay.
- Ordering: results leave strictly in acceptance order; no beat is dropped or duplicated.
- Inputs x/y/ctrl are ignored when in_valid=0 or in_ready=0.
- When out_valid=0, out/zr/ng hold their last values (0 after reset).

Optional Feature:
- Macro: HACK_ALU_CARRY_FLAGS_EN.
- When defined, two extra output ports are added, carried per beat exactly like zr/ng:
  - cf (1 bit): carry out of x2+y2 when f=1, else 0.
  - vf (1 bit): signed overflow of x2+y2 when f=1, else 0. This is taken before the no inversion.
  - Reset value of both is 0.
- When undefined, the ports and logic are absent, and behaviour is otherwise identical.

Test Plan:
- Reset for 2 cycles, then release. Expect out_valid=0, in_ready=1, out=0x0000, zr=0, ng=0.
- x=0x0005, y=0x0003, ctrl=000010 (x+y), out_ready=1. Expect out=0x0008, zr=0, ng=0, out_valid=1 one cycle after acceptance.
- Two further beats with out_ready=1:
  - x=0x0003, y=0x0005, ctrl=010011 (x-y): expect out=0xFFFE, ng=1.
  - ctrl=101010 (constant 0): expect out=0x0000, zr=1.
- Backpressure: hold out_ready=0 and drive 3 back-to-back beats (x&y with x=0x00FF, y=0x0F0F; x+y with x=1, y=1; -1 via ctrl 111010).
  - Expect in_ready=0 after 2 accepted beats, and the third beat held.
  - Release out_ready. Expect outputs 0x000F, 0x0002, 0xFFFF in order, with no loss.
- Assert reset while in TWO state. Next cycle expect out_valid=0 and in_ready=1; no stale beat appears.
- With HACK_ALU_CARRY_FLAGS_EN:
  - x=0x7FFF, y=0x0001, ctrl=000010: expect out=0x8000, vf=1, cf=0, ng=1.
  - x=0xFFFF, y=0x0001: expect out=0x0000, cf=1, zr=1.

Source files
------------

// File: rtl/hack_alu_stage.sv
// ---------------------------------------------------------------------------
// hack_alu_stage
//
// Registered Hack ALU stage. It takes an operand pair (x, y) and the six Hack
// control bits, computes the ALU result and its flags combinationally, and
// registers them into a 2-entry output buffer (main + skid). The output side
// is a valid/ready interface. in_ready comes straight from the buffer state,
// so downstream backpressure never reaches upstream combinationally.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   operand beat present
//   in_ready   stage can accept a beat this cycle (registered)
//   x, y       operands, WIDTH bits (x = D side, y = A/M side)
//   ctrl       {zx, nx, zy, ny, f, no}, ctrl[5] = zx
//   out_valid  result beat present
//   out_ready  downstream accepts the result
//   out        ALU result, WIDTH bits
//   zr, ng     result == 0, result sign bit
//   cf, vf     carry / signed overflow of the f=1 adder (only when the
//              HACK_ALU_CARRY_FLAGS_EN macro is defined)
//
// Optional feature macro: HACK_ALU_CARRY_FLAGS_EN
// ---------------------------------------------------------------------------
module hack_alu_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng
`ifdef HACK_ALU_CARRY_FLAGS_EN
  ,
  output logic             cf,
  output logic             vf
`endif
);

`ifdef HACK_ALU_CARRY_FLAGS_EN
  localparam int FLAG_BITS = 4;
`else
  localparam int FLAG_BITS = 2;
`endif
  // A buffered beat is the result followed by its flags, so the flags can
  // never get out of step with the value they describe.
  localparam int PW = WIDTH + FLAG_BITS;

  // The encoding is {main_valid, skid_valid}.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    TWO   = 2'b11
  } state_t;

  state_t state, state_next;

  logic [PW-1:0]    main_q, skid_q, beat;
  logic             load_main_in, load_main_skid, load_skid;
  logic             accept;

  logic             zx, nx, zy, ny, f, no;
  logic [WIDTH-1:0] x1, x2, y1, y2, sum, r, res;

  assign {zx, nx, zy, ny, f, no} = ctrl;

  // Operand preparation and the ALU core. Everything up to the packed beat is
  // pure combinational logic on the input side of the stage.
  assign x1  = zx ? '0 : x;
  assign x2  = nx ? ~x1 : x1;
  assign y1  = zy ? '0 : y;
  assign y2  = ny ? ~y1 : y1;
  assign r   = f ? sum : (x2 & y2);
  assign res = no ? ~r : r;

`ifdef HACK_ALU_CARRY_FLAGS_EN
  logic [WIDTH:0] sum_full;
  logic           carry, ovf;

  // The adder is widened by one bit to expose the carry. Overflow is taken
  // on the raw sum, before the 'no' inversion: it happens when both addends
  // share a sign and the sum's sign differs from it.
  assign sum_full = {1'b0, x2} + {1'b0, y2};
  assign sum      = sum_full[WIDTH-1:0];
  assign carry    = f & sum_full[WIDTH];
  assign ovf      = f & (x2[WIDTH-1] == y2[WIDTH-1]) & (sum[WIDTH-1] != x2[WIDTH-1]);
  assign beat     = {res, (res == '0), res[WIDTH-1], carry, ovf};
`else
  assign sum  = x2 + y2;
  assign beat = {res, (res == '0), res[WIDTH-1]};
`endif

  // Handshake signals. in_ready depends only on the state register, never
  // on out_ready, which keeps the upstream path free of combinational
  // backpressure.
  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid && in_ready;

  // Output data always reflects the main entry. Because main is only ever
  // written when a new beat lands there, out/zr/ng keep their last values
  // while the buffer is empty.
`ifdef HACK_ALU_CARRY_FLAGS_EN
  assign {out, zr, ng, cf, vf} = main_q;
`else
  assign {out, zr, ng} = main_q;
`endif

  // Next-state logic for the two-entry buffer. It also decides where an
  // accepted beat goes: straight into main when main is free or is being
  // drained this cycle, otherwise into skid. When the full buffer drains,
  // the skid beat moves up into main to preserve ordering.
  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_next   = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && out_ready) begin
          state_next   = ONE;
          load_main_in = 1'b1;
        end else if (accept) begin
          state_next = TWO;
          load_skid  = 1'b1;
        end else if (out_ready) begin
          state_next = EMPTY;
        end
      end
      TWO: begin
        if (out_ready) begin
          state_next     = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
  end

  // State and buffer registers. Reset drops every buffered beat and clears
  // the visible result and flags to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state <= state_next;
      if (load_main_in) begin
        main_q <= beat;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= beat;
      end
    end
  end

endmodule

// File: tb/tb_hack_alu_stage.sv
// ---------------------------------------------------------------------------
// tb_hack_alu_stage
//
// Self-checking bench for hack_alu_stage. The driver pushes the expected
// beat into a scoreboard queue whenever the stage accepts an input; an
// independent monitor pops and compares whenever a result transfers, and
// also checks that a stalled result stays put. Expected values come from
// directed constants or from an integer-arithmetic reference model.
// Builds with or without HACK_ALU_CARRY_FLAGS_EN.
// ---------------------------------------------------------------------------
module tb_hack_alu_stage;

  localparam int WIDTH = 16;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [5:0]       ctrl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zr;
  logic             ng;
`ifdef HACK_ALU_CARRY_FLAGS_EN
  logic             cf;
  logic             vf;
`endif

  int errors = 0;
  int checks = 0;

  // Expected beats in acceptance order: {out, zr, ng, cf, vf}.
  logic [19:0] expQ[$];

  hack_alu_stage #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .ctrl      (ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .zr        (zr),
    .ng        (ng)
`ifdef HACK_ALU_CARRY_FLAGS_EN
    ,
    .cf        (cf),
    .vf        (vf)
`endif
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packs a beat; the carry flags are dropped when the feature is absent.
  function automatic logic [19:0] pack(input logic [15:0] o, input logic z,
                                       input logic n, input logic c,
                                       input logic v);
`ifdef HACK_ALU_CARRY_FLAGS_EN
    return {o, z, n, c, v};
`else
    return {o, z, n, 2'b00};
`endif
  endfunction

  // What the DUT is presenting right now, in the same packing.
  function automatic logic [19:0] curOut();
`ifdef HACK_ALU_CARRY_FLAGS_EN
    return pack(out, zr, ng, cf, vf);
`else
    return pack(out, zr, ng, 1'b0, 1'b0);
`endif
  endfunction

  // Reference model: unsigned integers for the datapath, complement as
  // (2^16-1)-v, carry from an unbounded sum, overflow from signed range.
  function automatic logic [19:0] model(input logic [15:0] xa,
                                        input logic [15:0] ya,
                                        input logic [5:0] cb);
    int xv, yv, r, sx, sy, s;
    logic cy, ov;
    xv = cb[5] ? 0 : int'(xa);
    if (cb[4]) xv = 65535 - xv;
    yv = cb[3] ? 0 : int'(ya);
    if (cb[2]) yv = 65535 - yv;
    cy = 1'b0;
    ov = 1'b0;
    if (cb[1]) begin
      r  = (xv + yv) % 65536;
      cy = (xv + yv) > 65535;
      sx = (xv > 32767) ? xv - 65536 : xv;
      sy = (yv > 32767) ? yv - 65536 : yv;
      s  = sx + sy;
      ov = (s > 32767) || (s < -32768);
    end else begin
      r = xv & yv;
    end
    if (cb[0]) r = 65535 - r;
    return pack(r[15:0], r == 0, r > 32767, cy, ov);
  endfunction

  // Single comparison point; every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance n cycles, ending #1 after a rising edge.
  task automatic stepCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one beat and hold it until the stage accepts it (bounded).
  task automatic applyStimulus(input logic [15:0] xv, input logic [15:0] yv,
                               input logic [5:0] cv, input logic [19:0] expv);
    bit done;
    done     = 1'b0;
    x        = xv;
    y        = yv;
    ctrl     = cv;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      if (in_ready) begin
        expQ.push_back(expv);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checkOutput("accept", {31'd0, done}, 32'd1);
  endtask

  // Monitor: compares each transferred beat with the scoreboard head and
  // checks that a stalled beat is unchanged on the following cycle.
  initial begin : monitor
    bit          holdPending;
    logic [19:0] holdVal;
    logic [19:0] expv;
    holdPending = 1'b0;
    holdVal     = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        holdPending = 1'b0;
      end else begin
        if (holdPending) begin
          checkOutput("hold_valid", {31'd0, out_valid}, 32'd1);
          checkOutput("hold_data", {12'd0, curOut()}, {12'd0, holdVal});
        end
        holdPending = out_valid && !out_ready;
        holdVal     = curOut();
        if (out_valid && out_ready) begin
          if (expQ.size() == 0) begin
            checkOutput("spurious_beat", 32'd1, 32'd0);
          end else begin
            expv = expQ.pop_front();
            checkOutput("beat", {12'd0, curOut()}, {12'd0, expv});
          end
        end
      end
    end
  end

  // Hard bound on simulated time so the bench can never hang.
  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence.
  initial begin : driver
    logic [15:0] rx, ry;
    logic [5:0]  rc;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x         = '0;
    y         = '0;
    ctrl      = '0;

    // Two reset cycles, then check the idle state.
    stepCycles(2);
    reset = 1'b0;
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("reset_payload", {12'd0, curOut()}, 32'd0);

    // Directed beats with downstream always ready.
    out_ready = 1'b1;
    applyStimulus(16'h0005, 16'h0003, 6'b000010, pack(16'h0008, 1'b0, 1'b0, 1'b0, 1'b0));
    checkOutput("latency_valid", {31'd0, out_valid}, 32'd1);
    applyStimulus(16'h0003, 16'h0005, 6'b010011, pack(16'hFFFE, 1'b0, 1'b1, 1'b1, 1'b0));
    applyStimulus(16'h1234, 16'hABCD, 6'b101010, pack(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0));
    stepCycles(3);

    // Backpressure: two beats fill the buffer, the third must wait.
    out_ready = 1'b0;
    applyStimulus(16'h00FF, 16'h0F0F, 6'b000000, pack(16'h000F, 1'b0, 1'b0, 1'b0, 1'b0));
    applyStimulus(16'h0001, 16'h0001, 6'b000010, pack(16'h0002, 1'b0, 1'b0, 1'b0, 1'b0));
    checkOutput("full_in_ready", {31'd0, in_ready}, 32'd0);
    x        = 16'h5555;
    y        = 16'hAAAA;
    ctrl     = 6'b111010;
    in_valid = 1'b1;
    stepCycles(2);
    checkOutput("full_stall", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    applyStimulus(16'h5555, 16'hAAAA, 6'b111010, pack(16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0));
    stepCycles(3);
    checkOutput("drain_empty", expQ.size(), 32'd0);

    // Adder corner cases (carry/overflow flags when the feature is built).
    applyStimulus(16'h7FFF, 16'h0001, 6'b000010, pack(16'h8000, 1'b0, 1'b1, 1'b0, 1'b1));
    applyStimulus(16'hFFFF, 16'h0001, 6'b000010, pack(16'h0000, 1'b1, 1'b0, 1'b1, 1'b0));
    stepCycles(3);

    // Reset while both entries are full: nothing may come out afterwards.
    out_ready = 1'b0;
    rx = 16'($urandom);
    ry = 16'($urandom);
    applyStimulus(rx, ry, 6'b000010, model(rx, ry, 6'b000010));
    applyStimulus(ry, rx, 6'b010011, model(ry, rx, 6'b010011));
    checkOutput("two_in_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b1;
    stepCycles(1);
    reset = 1'b0;
    expQ.delete();
    checkOutput("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midreset_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("midreset_payload", {12'd0, curOut()}, 32'd0);
    out_ready = 1'b1;
    stepCycles(5);
    checkOutput("midreset_no_beat", {31'd0, out_valid}, 32'd0);

    // Randomised traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      rx        = 16'($urandom);
      ry        = 16'($urandom);
      rc        = 6'($urandom);
      x         = rx;
      y         = ry;
      ctrl      = rc;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if (in_valid && in_ready) begin
        expQ.push_back(model(rx, ry, rc));
      end
      stepCycles(1);
    end

    // Drain everything that is still buffered.
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && expQ.size() != 0; i++) begin
      stepCycles(1);
    end
    stepCycles(2);
    checkOutput("final_queue_empty", expQ.size(), 32'd0);
    checkOutput("final_out_valid", {31'd0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
